// File: rtl/cordic_angle_reducer.sv
// rtl/cordic_angle_reducer.sv - folds a signed angle into [0, 2*pi) and splits it into quadrant plus residual
module cordic_angle_reducer #(
  parameter int W        = 32,
  parameter int FRAC     = 28,
  parameter int TWO_PI   = 1686629713,
  parameter int PI       = 843314857,
  parameter int HALF_PI  = 421657428,
  parameter int PI_3_2   = 1264972285,
  parameter int MAX_WRAP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  input  logic         ack,
  output logic         busy,
  output logic         ready,
  output logic         err,
  output logic [1:0]   region,
  output logic [W-1:0] angle_red
);

  // Integer bits must cover 2*pi plus a sign bit, otherwise the constants do not fit.
  localparam int INT_BITS = W - FRAC;
  if (INT_BITS < 4) begin : g_bad_frac
    $error("cordic_angle_reducer: W-FRAC must be at least 4");
  end

  localparam int CW = (MAX_WRAP < 1) ? 1 : $clog2(MAX_WRAP + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WRAP);

  // Accumulator is one bit wider than the angle so a +/-2*pi step never overflows.
  localparam logic signed [W:0] TWO_PI_X = (W+1)'(TWO_PI);
  localparam logic signed [W:0] HALF_PI_X = (W+1)'(HALF_PI);
  localparam logic signed [W:0] PI_X = (W+1)'(PI);
  localparam logic signed [W:0] PI_3_2_X = (W+1)'(PI_3_2);

  // Quadrant base offsets; acc is non-negative and below 2*pi in QUAD so W-bit math suffices.
  localparam logic [W-1:0] HALF_PI_W = W'(HALF_PI);
  localparam logic [W-1:0] PI_W = W'(PI);
  localparam logic [W-1:0] PI_3_2_W = W'(PI_3_2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WRAP = 2'd1,
    S_QUAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic signed [W:0]    acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [1:0]           region_q, region_d;
  logic [W-1:0]         angle_red_q, angle_red_d;

  logic                 need_step;

  // Out of [0, 2*pi): another wrap step is required.
  always_comb begin
    need_step = (acc_q < 0) || (acc_q >= TWO_PI_X);
  end

  // Next-state and next-output computation for the reduction FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    region_d    = region_q;
    angle_red_d = angle_red_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = {angle_in[W-1], angle_in};
          cnt_d   = '0;
          state_d = S_WRAP;
        end
      end

      S_WRAP: begin
        if (need_step) begin
          if (cnt_q == MAX_CNT) begin
            err_d       = 1'b1;
            region_d    = 2'b00;
            angle_red_d = '0;
            state_d     = S_DONE;
          end else begin
            acc_d = acc_q[W] ? (acc_q + TWO_PI_X) : (acc_q - TWO_PI_X);
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_QUAD;
        end
      end

      S_QUAD: begin
        // Exact thresholds belong to the upper quadrant, hence >=.
        if (acc_q >= PI_3_2_X) begin
          region_d    = 2'b11;
          angle_red_d = acc_q[W-1:0] - PI_3_2_W;
        end else if (acc_q >= PI_X) begin
          region_d    = 2'b10;
          angle_red_d = acc_q[W-1:0] - PI_W;
        end else if (acc_q >= HALF_PI_X) begin
          region_d    = 2'b01;
          angle_red_d = acc_q[W-1:0] - HALF_PI_W;
        end else begin
          region_d    = 2'b00;
          angle_red_d = acc_q[W-1:0];
        end
        err_d   = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        // Ack wins over a simultaneous start; start is only honoured in IDLE.
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_DONE);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      region_q    <= 2'b00;
      angle_red_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      region_q    <= region_d;
      angle_red_q <= angle_red_d;
    end
  end

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign region    = region_q;
  assign angle_red = angle_red_q;

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// tb/tb_cordic_angle_reducer.sv - scoreboard bench for cordic_angle_reducer
module tb_cordic_angle_reducer;

  localparam int W = 32;
  localparam longint TWO_PI = 1686629713;
  localparam longint PI = 843314857;
  localparam longint HALF_PI = 421657428;
  localparam longint PI_3_2 = 1264972285;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start0, ack0, start1, ack1;
  logic [W-1:0] ang0, ang1;
  logic         busy0, ready0, err0, busy1, ready1, err1;
  logic [1:0]   region0, region1;
  logic [W-1:0] red0, red1;

  cordic_angle_reducer #(.MAX_WRAP(4)) dut (
    .clk(clk), .reset(reset), .start(start0), .angle_in(ang0), .ack(ack0),
    .busy(busy0), .ready(ready0), .err(err0), .region(region0), .angle_red(red0)
  );

  cordic_angle_reducer #(.MAX_WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .angle_in(ang1), .ack(ack1),
    .busy(busy1), .ready(ready1), .err(err1), .region(region1), .angle_red(red1)
  );

  typedef struct {
    logic [1:0]   region;
    logic [W-1:0] red;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  function automatic exp_t model(input longint a_in, input int mw);
    exp_t   e;
    longint a = a_in;
    longint base;
    int     cnt = 0;
    e.lat = 1;
    e.err = 1'b0;
    while (a < 0 || a >= TWO_PI) begin
      if (cnt == mw) begin
        e.err = 1'b1;
        e.region = 2'b00;
        e.red = '0;
        e.lat += 1;
        return e;
      end
      a = (a < 0) ? a + TWO_PI : a - TWO_PI;
      cnt++;
      e.lat++;
    end
    e.lat += 2;
    if (a >= PI_3_2) begin
      e.region = 2'b11; base = PI_3_2;
    end else if (a >= PI) begin
      e.region = 2'b10; base = PI;
    end else if (a >= HALF_PI) begin
      e.region = 2'b01; base = HALF_PI;
    end else begin
      e.region = 2'b00; base = 0;
    end
    e.red = W'(a - base);
    return e;
  endfunction

  task automatic run_op(input bit u, input logic [W-1:0] ang, input int hold, input string name);
    exp_t e;
    logic [1:0]   r;
    logic [W-1:0] d;
    logic         er;
    int lat = 0;
    bit seen = 0;
    sb.push_back(model(longint'(signed'(ang)), u ? 1 : 4));
    @(negedge clk);
    if (u) begin start1 = 1'b1; ang1 = ang; end
    else begin start0 = 1'b1; ang0 = ang; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      lat++;
      if ((u ? ready1 : ready0) === 1'b1) seen = 1;
    end
    e = sb.pop_front();
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: ready never rose, required within 40 cycles", name);
      return;
    end
    r = u ? region1 : region0;
    d = u ? red1 : red0;
    er = u ? err1 : err0;
    n_tests++;
    if (r !== e.region) begin n_fail++; $display("FAIL %s region: got %b want %b", name, r, e.region); end
    n_tests++;
    if (d !== e.red) begin n_fail++; $display("FAIL %s angle_red: got %0d want %0d", name, d, e.red); end
    n_tests++;
    if (er !== e.err) begin n_fail++; $display("FAIL %s err: got %b want %b", name, er, e.err); end
    n_tests++;
    if (lat !== e.lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_tests++;
      if ((u ? ready1 : ready0) !== 1'b1 || (u ? region1 : region0) !== e.region ||
          (u ? red1 : red0) !== e.red || (u ? err1 : err0) !== e.err) begin
        n_fail++;
        $display("FAIL %s hold cycle %0d: ready=%b region=%b red=%0d err=%b want ready=1 region=%b red=%0d err=%b",
                 name, i, (u ? ready1 : ready0), (u ? region1 : region0), (u ? red1 : red0), (u ? err1 : err0),
                 e.region, e.red, e.err);
      end
    end
    @(negedge clk);
    if (u) ack1 = 1'b1; else ack0 = 1'b1;
    @(posedge clk); #1;
    ack0 = 1'b0; ack1 = 1'b0;
    n_tests++;
    if ((u ? ready1 : ready0) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready after ack: got %b want 0", name, (u ? ready1 : ready0));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy0 !== 1'b0 || ready0 !== 1'b0 || err0 !== 1'b0) begin
      n_fail++; $display("FAIL reset flags: busy=%b ready=%b err=%b want 0 0 0", busy0, ready0, err0);
    end
    n_tests++;
    if (region0 !== 2'b00 || red0 !== '0) begin
      n_fail++; $display("FAIL reset data: region=%b red=%0d want 00 0", region0, red0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_op(0, 32'd268435456, 0, "one_rad");
  endtask

  task automatic test_thresholds();
    run_op(0, 32'd843314857, 0, "pi");
    run_op(0, 32'd421657428, 0, "half_pi");
    run_op(0, 32'd421657427, 0, "below_half_pi");
    run_op(0, 32'd1264972285, 0, "three_half_pi");
    run_op(0, 32'd1686629712, 0, "below_two_pi");
  endtask

  task automatic test_negative();
    run_op(0, -32'sd268435456, 0, "minus_one_rad");
    run_op(0, 32'h8000_0000, 0, "min_angle_two_wraps");
  endtask

  task automatic test_two_pi_hold();
    run_op(0, 32'd1686629713, 10, "two_pi_hold");
  endtask

  task automatic test_err();
    run_op(1, 32'h8000_0000, 2, "wrap_limit_err");
    run_op(1, -32'sd268435456, 0, "limit1_one_wrap_ok");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start0 = 1'b1; ang0 = 32'h8000_0000;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL mid_reset busy before reset: got %b want 1", busy0); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset abort: busy=%b ready=%b want 0 0", busy0, ready0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (ready0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset no result: busy=%b ready=%b want 0 0", busy0, ready0);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    @(negedge clk);
    start0 = 1'b1; ang0 = 32'd268435456;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      if (ready0 === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL b2b timeout: ready never rose, required within 40 cycles"); end
    @(negedge clk);
    start0 = 1'b1; ang0 = 32'd843314857;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ready0 !== 1'b1 || region0 !== 2'b00 || red0 !== 32'd268435456) begin
      n_fail++; $display("FAIL b2b start_in_done: ready=%b region=%b red=%0d want 1 00 268435456", ready0, region0, red0);
    end
    @(negedge clk);
    start0 = 1'b1; ack0 = 1'b1; ang0 = 32'd843314857;
    @(posedge clk); #1;
    start0 = 1'b0; ack0 = 1'b0;
    n_tests++;
    if (ready0 !== 1'b0) begin n_fail++; $display("FAIL b2b ack_wins ready: got %b want 0", ready0); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b start_dropped busy: got %b want 0", busy0); end
    run_op(0, 32'd843314857, 0, "b2b_after_ack");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_op(0, $urandom(), 0, "random_mw4");
    for (int i = 0; i < 4; i++) run_op(1, $urandom(), 0, "random_mw1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start0 = 1'b0; ack0 = 1'b0; ang0 = '0;
    start1 = 1'b0; ack1 = 1'b0; ang1 = '0;
    test_reset();
    test_basic();
    test_thresholds();
    test_negative();
    test_two_pi_hold();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
